alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 32 +++
 rtl/alu_sequencer_div_seq.sv | 82 ++++++++
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer and its divider.
package alu_sequencer_pkg;

    localparam int OPW = 3;
    localparam int DW  = 8;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_EQ  = 3'd5,
        OP_GT  = 3'd6,
        OP_LT  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DIVIDE = 3'd4,
        ST_OUT    = 3'd5
    } state_e;

    // Only the low OPW bits select an operation; any set upper bit is illegal.
    function automatic logic is_legal_op(input logic [DW-1:0] op_byte);
        return (op_byte[DW-1:OPW] == 5'd0);
    endfunction

endpackage

// File: rtl/alu_sequencer_div_seq.sv
// Eight-iteration restoring divider; the first iteration happens on the start edge.
module div_seq
    import alu_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    logic [DW-1:0]   rem_r;
    logic [DW-1:0]   quo_r;
    logic [DW-1:0]   dvs_r;
    logic [3:0]      cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [2*DW-1:0] first_step_s;
    logic [2*DW-1:0] next_step_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*DW-1:0] div_step(
        input logic [DW-1:0] rem,
        input logic [DW-1:0] quo,
        input logic [DW-1:0] dvs
    );
        logic [DW:0] shifted;
        logic [DW:0] diff;
        shifted = {rem, quo[DW-1]};
        diff    = shifted - {1'b0, dvs};
        if (shifted >= {1'b0, dvs}) begin
            return {diff[DW-1:0], quo[DW-2:0], 1'b1};
        end else begin
            return {shifted[DW-1:0], quo[DW-2:0], 1'b0};
        end
    endfunction

    // Step values for the start edge and for subsequent busy edges.
    always_comb begin
        first_step_s = div_step(8'h00, dividend, divisor);
        next_step_s  = div_step(rem_r, quo_r, dvs_r);
    end

    // Iteration counter and shift registers; done pulses after the eighth step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= 8'h00;
            quo_r  <= 8'h00;
            dvs_r  <= 8'h00;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= first_step_s[2*DW-1:DW];
            quo_r  <= first_step_s[DW-1:0];
            dvs_r  <= divisor;
            cnt_r  <= 4'd1;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= next_step_s[2*DW-1:DW];
            quo_r <= next_step_s[DW-1:0];
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r == 4'd7) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/alu_sequencer.sv
// Byte-serial ALU: collects opcode/A/B, computes, and holds a registered result until taken.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter bit DIV0_ERR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_result,
    output logic          out_flag,
    output logic          out_err
);

    state_e        state_r;
    logic [DW-1:0] op_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [15:0]   out_result_r;
    logic          out_flag_r;
    logic          out_err_r;

    opcode_e       op_s;
    logic [DW-1:0] sum_s;
    logic [DW-1:0] diff_s;
    logic [15:0]   exec_result_s;
    logic          exec_flag_s;
    logic          exec_err_s;
    logic          needs_div_s;
    logic          div_start_s;
    logic          div_done_s;
    logic [DW-1:0] div_quo_s;
    logic [DW-1:0] div_rem_s;

    // Single-cycle results; DIV/MOD with a nonzero divisor defer to the divider.
    always_comb begin
        op_s          = opcode_e'(op_r[OPW-1:0]);
        sum_s         = a_r + b_r;
        diff_s        = a_r - b_r;
        exec_result_s = 16'h0000;
        exec_flag_s   = 1'b0;
        exec_err_s    = 1'b0;
        needs_div_s   = 1'b0;
        if (!is_legal_op(op_r)) begin
            exec_err_s = 1'b1;
        end else begin
            case (op_s)
                OP_ADD: exec_result_s = {8'h00, sum_s};
                OP_SUB: exec_result_s = {8'h00, diff_s};
                OP_MUL: exec_result_s = {8'h00, a_r} * {8'h00, b_r};
                OP_DIV,
                OP_MOD: begin
                    if (b_r == 8'h00) begin
                        exec_err_s = DIV0_ERR;
                    end else begin
                        needs_div_s = 1'b1;
                    end
                end
                OP_EQ:  exec_flag_s = (a_r == b_r);
                OP_GT:  exec_flag_s = (a_r > b_r);
                OP_LT:  exec_flag_s = (a_r < b_r);
                default: exec_err_s = 1'b1;
            endcase
        end
    end

    assign div_start_s = (state_r == ST_EXEC) && needs_div_s;

    div_seq u_div_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .dividend  (a_r),
        .divisor   (b_r),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Packet FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= 8'h00;
            a_r          <= 8'h00;
            b_r          <= 8'h00;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= 16'h0000;
            out_flag_r   <= 1'b0;
            out_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        op_r    <= in_data;
                        state_r <= ST_GET_A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GET_A: begin
                    if (in_valid && in_ready_r) begin
                        a_r     <= in_data;
                        state_r <= ST_GET_B;
                    end else begin
                        state_r <= ST_GET_A;
                    end
                end
                ST_GET_B: begin
                    if (in_valid && in_ready_r) begin
                        b_r        <= in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_EXEC;
                    end else begin
                        state_r <= ST_GET_B;
                    end
                end
                ST_EXEC: begin
                    if (needs_div_s) begin
                        state_r <= ST_DIVIDE;
                    end else begin
                        out_result_r <= exec_result_s;
                        out_flag_r   <= exec_flag_s;
                        out_err_r    <= exec_err_s;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_OUT;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done_s) begin
                        if (op_s == OP_DIV) begin
                            out_result_r <= {div_rem_s, div_quo_s};
                        end else begin
                            out_result_r <= {8'h00, div_rem_s};
                        end
                        out_flag_r  <= 1'b0;
                        out_err_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_flag   = out_flag_r;
    assign out_err    = out_err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed expected results.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_flag;
    logic        out_err;

    int total_cnt;
    int bad_cnt;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        check_val("in_ready_before_byte", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Counts edges after the B transfer until out_valid; 0 means timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_pkt(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_res,
                           input logic exp_flag, input logic exp_err, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        send_byte(op);
        send_byte(a);
        send_byte(b);
        wait_result(lat);
        check_val({tag, "_latency"}, 16'(lat), 16'(exp_lat));
        check_val({tag, "_result"}, out_result, exp_res);
        check_val({tag, "_flag"}, {15'd0, out_flag}, {15'd0, exp_flag});
        check_val({tag, "_err"}, {15'd0, out_err}, {15'd0, exp_err});
        @(posedge clk);
        #1;
        check_val({tag, "_valid_one_cycle"}, {15'd0, out_valid}, 16'd0);
        check_val({tag, "_ready_after"}, {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] held_res;
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check_val("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check_val("rst_out_result", out_result, 16'h0000);
        check_val("rst_flags", {14'd0, out_flag, out_err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("in_ready_after_release", {15'd0, in_ready}, 16'd1);

        run_pkt("add_wrap", 8'h00, 8'hC8, 8'h64, 16'h002C, 1'b0, 1'b0, 1);
        run_pkt("div", 8'h03, 8'h64, 8'h07, 16'h020E, 1'b0, 1'b0, 9);
        run_pkt("div_ff_10", 8'h03, 8'hFF, 8'h10, 16'h0F0F, 1'b0, 1'b0, 9);
        run_pkt("mod", 8'h04, 8'h64, 8'h07, 16'h0002, 1'b0, 1'b0, 9);
        run_pkt("mul_max", 8'h02, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1);
        run_pkt("sub_borrow", 8'h01, 8'h00, 8'h01, 16'h00FF, 1'b0, 1'b0, 1);
        run_pkt("mod_by_zero", 8'h04, 8'h05, 8'h00, 16'h0000, 1'b0, 1'b1, 1);
        run_pkt("div_by_zero", 8'h03, 8'h07, 8'h00, 16'h0000, 1'b0, 1'b1, 1);
        run_pkt("eq_false", 8'h05, 8'h01, 8'h02, 16'h0000, 1'b0, 1'b0, 1);
        run_pkt("lt_true", 8'h07, 8'h03, 8'h09, 16'h0000, 1'b1, 1'b0, 1);
        run_pkt("gt_equal", 8'h06, 8'h09, 8'h09, 16'h0000, 1'b0, 1'b0, 1);

        // Backpressure: hold the GT result for five cycles while junk bytes are offered.
        out_ready = 1'b0;
        send_byte(8'h06);
        send_byte(8'h09);
        send_byte(8'h03);
        wait_result(lat);
        check_val("bp_latency", 16'(lat), 16'd1);
        check_val("bp_flag", {15'd0, out_flag}, 16'd1);
        held_res = out_result;
        check_val("bp_result", held_res, 16'h0000);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_valid_held", {15'd0, out_valid}, 16'd1);
            check_val("bp_ready_low", {15'd0, in_ready}, 16'd0);
            check_val("bp_flag_held", {14'd0, out_flag, out_err}, 16'd2);
            check_val("bp_result_held", out_result, 16'h0000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_transfer_valid", {15'd0, out_valid}, 16'd0);
        check_val("bp_transfer_ready", {15'd0, in_ready}, 16'd1);

        // Reset mid-divide must discard the packet.
        send_byte(8'h03);
        send_byte(8'hFF);
        send_byte(8'h01);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("middiv_rst_valid", {15'd0, out_valid}, 16'd0);
        check_val("middiv_rst_ready", {15'd0, in_ready}, 16'd0);
        check_val("middiv_rst_result", out_result, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_val("post_rst_no_valid", {15'd0, out_valid}, 16'd0);
        end
        run_pkt("eq_after_rst", 8'h05, 8'h2A, 8'h2A, 16'h0000, 1'b1, 1'b0, 1);
        run_pkt("illegal_op", 8'h1F, 8'h01, 8'h02, 16'h0000, 1'b0, 1'b1, 1);
        run_pkt("illegal_hi", 8'h80, 8'h10, 8'h20, 16'h0000, 1'b0, 1'b1, 1);
        run_pkt("add_plain", 8'h00, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
